spi_cmd_regs: RTL and testbench

// - Byte-level command decoder and register bank downstream of the SPI slave byte engine.
// - Consumes received bytes and SSEL message framing; drives the next byte the slave shifts out on MISO.
// - Protocol: byte0 = command {rw, addr[6:0]} (rw=1 read, rw=0 write).
// - Following bytes write or read consecutive addresses with auto-increment.

---
 rtl/spi_cmd_regs.sv | 202 ++++++++++++++++++++
 tb/tb_spi_cmd_regs.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regs.sv
// -----------------------------------------------------------------------------
// spi_cmd_regs
// Byte-level command decoder and register bank that sits behind an SPI slave
// byte engine. The first byte of each SSEL-framed message is a command
// {rw, addr[6:0]} (rw=1 read, rw=0 write). The bytes that follow write or read
// consecutive addresses. The address auto-increments and wraps from 0x7F to 0x00.
//
// Optional feature macro: SPI_CMD_COUNTER_EN
//   When this macro is defined, the block adds a free-running 32-bit counter.
//   The counter is snapshotted at msg_start. Reads at 0x40..0x43 return the
//   snapshot, LSB first. When the macro is undefined, those addresses read 8'hFF.
//
// Parameters
//   NREGS    number of 8-bit R/W registers at addresses 0..NREGS-1 (1..64)
//   ID_BYTE  byte presented on MISO while the command byte is shifted in
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   msg_start  1-clk pulse on SSEL falling edge (already synchronised)
//   msg_end    1-clk pulse on SSEL rising edge (already synchronised)
//   rx_valid   1-clk pulse, a complete byte is on rx_data
//   rx_data    received byte
//   tx_data    byte the slave loads at its next byte boundary
//   reg_out    flat register contents, reg[i] at [8i+7:8i]
//   wr_pulse   1-clk pulse per register write
//   wr_addr    address of the write, valid with wr_pulse
//   busy       high while a message is open
// -----------------------------------------------------------------------------
module spi_cmd_regs #(
    parameter int         NREGS   = 8,
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_start,
    input  logic               msg_end,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic [7:0]         tx_data,
    output logic [NREGS*8-1:0] reg_out,
    output logic               wr_pulse,
    output logic [6:0]         wr_addr,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    localparam logic [7:0] NREGS_W = 8'(NREGS);

    state_t      state_reg, state_next;
    logic [6:0]  addr_reg, addr_next;
    logic [7:0]  tx_reg, tx_next;
    // Read data is fetched one clock after the address settles. This keeps the
    // register mux off the rx_valid path. Total latency is 2 clk, which fits
    // inside an SCK half-period.
    logic        rd_load_reg, rd_load_next;
    logic        wr_pulse_reg, wr_pulse_next;
    logic [6:0]  wr_addr_reg, wr_addr_next;
    logic        wr_en;
    logic        addr_mapped;
    logic [7:0]  rd_data;
    logic [7:0]  reg_view [NREGS];

`ifdef SPI_CMD_COUNTER_EN
    logic [31:0] counter_reg;
    logic [31:0] snap_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_reg <= 32'd0;
            snap_reg    <= 32'd0;
        end else begin
            counter_reg <= counter_reg + 32'd1;
            if (msg_start) begin
                snap_reg <= counter_reg;
            end
        end
    end
`endif

    // Register bank: each byte is a plain flop group so every bit is visible on reg_out.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [7:0] byte_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_reg <= 8'h00;
                end else if (wr_en && (addr_reg == 7'(gi))) begin
                    byte_reg <= rx_data;
                end
            end

            assign reg_view[gi]        = byte_reg;
            assign reg_out[8*gi +: 8]  = byte_reg;
        end
    endgenerate

    assign addr_mapped = ({1'b0, addr_reg} < NREGS_W);

    // Read mux. Unmapped addresses return 8'hFF.
    always_comb begin
        rd_data = 8'hFF;
        for (int i = 0; i < NREGS; i++) begin
            if (addr_reg == 7'(i)) begin
                rd_data = reg_view[i];
            end
        end
`ifdef SPI_CMD_COUNTER_EN
        case (addr_reg)
            7'h40:   rd_data = snap_reg[7:0];
            7'h41:   rd_data = snap_reg[15:8];
            7'h42:   rd_data = snap_reg[23:16];
            7'h43:   rd_data = snap_reg[31:24];
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        tx_next      = tx_reg;
        rd_load_next = 1'b0;
        wr_en        = 1'b0;

        if (msg_start) begin
            // A new frame overrides everything, including a coincident byte.
            state_next = CMD;
            tx_next    = ID_BYTE;
        end else if (msg_end) begin
            // tx_data keeps its value, and any pending read fetch is dropped.
            state_next = IDLE;
        end else begin
            if (rd_load_reg) begin
                tx_next = rd_data;
            end
            case (state_reg)
                CMD: begin
                    if (rx_valid) begin
                        addr_next = rx_data[6:0];
                        if (rx_data[7]) begin
                            state_next   = READ;
                            rd_load_next = 1'b1;
                        end else begin
                            state_next = WRITE;
                            tx_next    = 8'h00;
                        end
                    end
                end
                WRITE: begin
                    if (rx_valid) begin
                        wr_en     = 1'b1;
                        addr_next = addr_reg + 7'd1;
                        tx_next   = 8'h00;
                    end
                end
                READ: begin
                    if (rx_valid) begin
                        addr_next    = addr_reg + 7'd1;
                        rd_load_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        wr_pulse_next = wr_en && addr_mapped;
        wr_addr_next  = wr_pulse_next ? addr_reg : wr_addr_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= 7'd0;
            tx_reg       <= 8'h00;
            rd_load_reg  <= 1'b0;
            wr_pulse_reg <= 1'b0;
            wr_addr_reg  <= 7'd0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            tx_reg       <= tx_next;
            rd_load_reg  <= rd_load_next;
            wr_pulse_reg <= wr_pulse_next;
            wr_addr_reg  <= wr_addr_next;
        end
    end

    assign tx_data  = tx_reg;
    assign wr_pulse = wr_pulse_reg;
    assign wr_addr  = wr_addr_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_cmd_regs.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_regs
// Bench for spi_cmd_regs. It runs directed scenarios followed by randomised
// messages. The reference model is a byte array plus a message-level view of
// the protocol:
//   - the address advances per byte;
//   - writes land when the address is below NREGS;
//   - reads return the register, the counter snapshot (when enabled), or 8'hFF.
// -----------------------------------------------------------------------------
module tb_spi_cmd_regs;

    localparam int         NREGS   = 8;
    localparam logic [7:0] ID_BYTE = 8'hA5;

    logic               clk;
    logic               rst_n;
    logic               msg_start;
    logic               msg_end;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic [7:0]         tx_data;
    logic [NREGS*8-1:0] reg_out;
    logic               wr_pulse;
    logic [6:0]         wr_addr;
    logic               busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_regs [NREGS];
    logic [31:0] snap_model;
    logic [31:0] tb_cnt;
    logic [6:0]  got_pulses [$];

    spi_cmd_regs #(
        .NREGS   (NREGS),
        .ID_BYTE (ID_BYTE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .msg_start (msg_start),
        .msg_end   (msg_end),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_data   (tx_data),
        .reg_out   (reg_out),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock cycles elapsed since reset release, i.e. what a free-running counter reads.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 32'd0;
        else        tb_cnt <= tb_cnt + 32'd1;
    end

    // Collect every write strobe the DUT emits.
    always @(negedge clk) begin
        if (rst_n && wr_pulse) got_pulses.push_back(wr_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        if (int'(a) < NREGS) return model_regs[int'(a)];
`ifdef SPI_CMD_COUNTER_EN
        if (a == 7'h40) return snap_model[7:0];
        if (a == 7'h41) return snap_model[15:8];
        if (a == 7'h42) return snap_model[23:16];
        if (a == 7'h43) return snap_model[31:24];
`endif
        return 8'hFF;
    endfunction

    task automatic check_regs(input string tag);
        logic [63:0] e;
        e = '0;
        for (int i = 0; i < NREGS; i++) e[8*i +: 8] = model_regs[i];
        check(tag, reg_out, e);
    endtask

    task automatic open_msg();
        msg_start = 1'b1;
        snap_model = tb_cnt;
        tick();
        msg_start = 1'b0;
        check("open_busy", 64'(busy), 64'd1);
        check("open_tx_id", 64'(tx_data), 64'(ID_BYTE));
    endtask

    task automatic close_msg();
        logic [7:0] tx_before;
        tx_before = tx_data;
        msg_end = 1'b1;
        tick();
        msg_end = 1'b0;
        tick();
        check("close_busy", 64'(busy), 64'd0);
        check("close_tx_hold", 64'(tx_data), 64'(tx_before));
    endtask

    // One byte strobe. On return, exactly two active edges have passed since
    // rx_valid was sampled, which is the deadline for tx_data.
    task automatic pulse_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic run_msg(input logic [7:0] cmd, input int n, input logic [63:0] data);
        logic [6:0] a;
        logic [7:0] b;
        logic [6:0] exp_q [$];
        open_msg();
        got_pulses.delete();
        a = cmd[6:0];
        repeat (3) tick();
        pulse_rx(cmd);
        if (cmd[7]) check("rd_cmd_tx", 64'(tx_data), 64'(model_rd(a)));
        else        check("wr_cmd_tx", 64'(tx_data), 64'd0);
        for (int i = 0; i < n; i++) begin
            b = data[8*i +: 8];
            repeat (4) tick();
            pulse_rx(b);
            if (cmd[7]) begin
                a = a + 7'd1;
                check("rd_data_tx", 64'(tx_data), 64'(model_rd(a)));
            end else begin
                if (int'(a) < NREGS) begin
                    model_regs[int'(a)] = b;
                    exp_q.push_back(a);
                end
                a = a + 7'd1;
                check("wr_data_tx", 64'(tx_data), 64'd0);
            end
        end
        repeat (3) tick();
        close_msg();
        check("wr_pulse_count", 64'(got_pulses.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_pulses.size()) check("wr_addr", 64'(got_pulses[i]), 64'(exp_q[i]));
        end
        check_regs("reg_out");
        $display("msg cmd=%02h bytes=%0d writes=%0d", cmd, n, exp_q.size());
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [6:0]  addr;
        logic [63:0] data;
        logic [63:0] regs_before;
        int          n;

        rst_n     = 1'b0;
        msg_start = 1'b0;
        msg_end   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        snap_model = 32'd0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;

        repeat (3) tick();
        check("rst_tx", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_reg_out", reg_out, 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Byte strobes while idle must be ignored.
        pulse_rx(8'h03);
        repeat (2) tick();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_tx", 64'(tx_data), 64'd0);
        check("idle_regs", reg_out, 64'd0);
        $display("idle byte 03 ignored");

        // Directed messages.
        run_msg(8'h02, 2, 64'h2211);
        run_msg(8'h82, 2, 64'h0000);
        run_msg(8'h7F, 2, 64'hBBAA);
        run_msg(8'hC0, 4, 64'h0);

        // Abort a write after its command byte; no register may change.
        regs_before = reg_out;
        open_msg();
        repeat (3) tick();
        pulse_rx(8'h01);
        repeat (2) tick();
        close_msg();
        check("abort_regs", reg_out, regs_before);
        $display("abort after cmd 01");

        // A msg_start coinciding with a byte strobe drops that byte.
        msg_start = 1'b1;
        rx_valid  = 1'b1;
        rx_data   = 8'h05;
        snap_model = tb_cnt;
        tick();
        msg_start = 1'b0;
        rx_valid  = 1'b0;
        tick();
        check("coinc_busy", 64'(busy), 64'd1);
        check("coinc_tx_id", 64'(tx_data), 64'(ID_BYTE));
        repeat (3) tick();
        pulse_rx(8'h81);
        check("coinc_rd_tx", 64'(tx_data), 64'(model_rd(7'h01)));
        repeat (3) tick();
        close_msg();
        $display("coincident start+byte, then cmd 81");

        // Reset in the middle of a write message.
        open_msg();
        pulse_rx(8'h05);
        repeat (3) tick();
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        tick();
        rx_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_tx", 64'(tx_data), 64'd0);
        check("midrst_wr_pulse", 64'(wr_pulse), 64'd0);
        check("midrst_regs", reg_out, 64'd0);
        for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        $display("reset mid-message");

        // Randomised messages around the interesting address regions.
        for (int m = 0; m < 40; m++) begin
            case ($urandom_range(0, 3))
                0:       addr = 7'($urandom_range(0, NREGS - 1));
                1:       addr = 7'($urandom_range(8'h7C, 8'h7F));
                2:       addr = 7'($urandom_range(8'h3E, 8'h45));
                default: addr = 7'($urandom_range(0, 127));
            endcase
            cmd  = {1'($urandom_range(0, 1)), addr};
            n    = int'($urandom_range(0, 6));
            data = {$urandom, $urandom};
            run_msg(cmd, n, data);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
